// File: rtl/mc_control_if.sv
// Bundle between the multicycle control sequencer and the datapath.
// master = sequencer (drives selects/enables), slave = datapath side (drives cmd/eq/stall).
interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic [3:0]       cmd;
  logic             eq;
  logic [2:0]       aluOp;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       pcSrc;
  logic             memIn;
  logic             dst;
  logic             regIn;
  logic             pcWe;
  logic             memWe;
  logic             irWe;
  logic             aWe;
  logic             bWe;
  logic             regWe;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    input  stall, cmd, eq,
    output aluOp, aluSrcA, aluSrcB, pcSrc, memIn, dst, regIn,
    output pcWe, memWe, irWe, aWe, bWe, regWe, illegal, retired, state
  );

  modport slave (
    output stall, cmd, eq,
    input  aluOp, aluSrcA, aluSrcB, pcSrc, memIn, dst, regIn,
    input  pcWe, memWe, irWe, aWe, bWe, regWe, illegal, retired, state
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control sequencer: Moore FSM decoding current state into datapath
// selects and write enables, with stall gating, illegal-opcode pulse and retire counter.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JREG   = 4'd12,
    S_ILL    = 4'd13
  } state_e;

  localparam logic [3:0] CMD_LW   = 4'd0;
  localparam logic [3:0] CMD_SW   = 4'd1;
  localparam logic [3:0] CMD_J    = 4'd2;
  localparam logic [3:0] CMD_JR   = 4'd3;
  localparam logic [3:0] CMD_BEQ  = 4'd4;
  localparam logic [3:0] CMD_BNE  = 4'd5;
  localparam logic [3:0] CMD_ADDI = 4'd6;
  localparam logic [3:0] CMD_XORI = 4'd7;
  localparam logic [3:0] CMD_ADD  = 4'd8;
  localparam logic [3:0] CMD_SUB  = 4'd9;
  localparam logic [3:0] CMD_SLT  = 4'd10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       mem_in;
  logic       dst;
  logic       reg_in;
  logic       pc_we;
  logic       mem_we;
  logic       ir_we;
  logic       a_we;
  logic       b_we;
  logic       reg_we;
  logic       illegal;

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.cmd)
          CMD_LW, CMD_SW:           state_d = S_MEMADR;
          CMD_J:                    state_d = S_JUMP;
          CMD_JR:                   state_d = S_JREG;
          CMD_BEQ, CMD_BNE:         state_d = S_BRANCH;
          CMD_ADDI, CMD_XORI:       state_d = S_EXEC_I;
          CMD_ADD, CMD_SUB, CMD_SLT: state_d = S_EXEC_R;
          default:                  state_d = S_ILL;
        endcase
      end
      S_MEMADR: state_d = (bus.cmd == CMD_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JREG: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      default:  state_d = S_FETCH;
    endcase
    if (bus.stall) begin
      state_d   = state_q;
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Outputs decode the current state only (eq/cmd just refine BRANCH and EXEC ops).
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    pc_src    = 2'd0;
    mem_in    = 1'b0;
    dst       = 1'b0;
    reg_in    = 1'b0;
    pc_we     = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    a_we      = 1'b0;
    b_we      = 1'b0;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we     = 1'b1;
        alu_src_b = 2'd3;
        pc_src    = 2'd1;
        pc_we     = 1'b1;
      end
      S_DECODE: begin
        a_we = 1'b1;
        b_we = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
      end
      S_MEMRD:  mem_in = 1'b1;
      S_MEMWB: begin
        mem_in = 1'b1;
        dst    = 1'b1;
        reg_we = 1'b1;
      end
      S_MEMWR: begin
        mem_in = 1'b1;
        mem_we = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (bus.cmd)
          CMD_SUB: alu_op = ALU_SUB;
          CMD_SLT: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_RWB: begin
        reg_in = 1'b1;
        reg_we = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = (bus.cmd == CMD_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_IWB: begin
        reg_in = 1'b1;
        dst    = 1'b1;
        reg_we = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_SUB;
        pc_we     = (bus.cmd == CMD_BNE) ? ~bus.eq : bus.eq;
      end
      S_JUMP: begin
        pc_src = 2'd2;
        pc_we  = 1'b1;
      end
      S_JREG: begin
        pc_src = 2'd3;
        pc_we  = 1'b1;
      end
      S_ILL:   illegal = 1'b1;
      default: ;
    endcase
    if (bus.stall || reset) begin
      pc_we   = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      a_we    = 1'b0;
      b_we    = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
    end
    // Selects stay valid under stall so the datapath keeps its operands steady.
    if (reset) begin
      alu_op    = ALU_ADD;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      pc_src    = 2'd0;
      mem_in    = 1'b0;
      dst       = 1'b0;
      reg_in    = 1'b0;
    end
  end

  assign bus.aluOp   = alu_op;
  assign bus.aluSrcA = alu_src_a;
  assign bus.aluSrcB = alu_src_b;
  assign bus.pcSrc   = pc_src;
  assign bus.memIn   = mem_in;
  assign bus.dst     = dst;
  assign bus.regIn   = reg_in;
  assign bus.pcWe    = pc_we;
  assign bus.memWe   = mem_we;
  assign bus.irWe    = ir_we;
  assign bus.aWe     = a_we;
  assign bus.bWe     = b_we;
  assign bus.regWe   = reg_we;
  assign bus.illegal = illegal;
  assign bus.retired = retired_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle state/enable/select vectors for every
// instruction class, stall and reset behaviour, and retire-counter wrap on a narrow instance.
module tb_mc_control;

  logic clk = 1'b0;
  logic reset;
  logic reset_w;

  always #5 clk = ~clk;

  mc_control_if #(.CNT_W(32)) bus ();
  mc_control_if #(.CNT_W(4))  bus_w ();

  mc_control #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mc_control #(.CNT_W(4)) dut_w (
    .clk   (clk),
    .reset (reset_w),
    .bus   (bus_w)
  );

  // en  = {pcWe, memWe, irWe, aWe, bWe, regWe, illegal}
  // sel = {aluOp[2:0], aluSrcA, aluSrcB[1:0], pcSrc[1:0], memIn, dst, regIn}
  logic [6:0]  en_obs;
  logic [10:0] sel_obs;
  assign en_obs  = {bus.pcWe, bus.memWe, bus.irWe, bus.aWe, bus.bWe, bus.regWe, bus.illegal};
  assign sel_obs = {bus.aluOp, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.memIn, bus.dst, bus.regIn};

  localparam logic [6:0] EN_NONE   = 7'b0000000;
  localparam logic [6:0] EN_FETCH  = 7'b1010000;
  localparam logic [6:0] EN_DECODE = 7'b0001100;
  localparam logic [6:0] EN_REG    = 7'b0000010;
  localparam logic [6:0] EN_MEMWR  = 7'b0100000;
  localparam logic [6:0] EN_PC     = 7'b1000000;
  localparam logic [6:0] EN_ILL    = 7'b0000001;

  localparam logic [10:0] SEL_ZERO    = 11'd0;
  localparam logic [10:0] SEL_FETCH   = {3'd0, 1'b0, 2'd3, 2'd1, 3'b000};
  localparam logic [10:0] SEL_MEMADR  = {3'd0, 1'b1, 2'd1, 2'd0, 3'b000};
  localparam logic [10:0] SEL_MEMRD   = {3'd0, 1'b0, 2'd0, 2'd0, 3'b100};
  localparam logic [10:0] SEL_MEMWB   = {3'd0, 1'b0, 2'd0, 2'd0, 3'b110};
  localparam logic [10:0] SEL_EXR_ADD = {3'd0, 1'b1, 2'd2, 2'd0, 3'b000};
  localparam logic [10:0] SEL_EXR_SUB = {3'd1, 1'b1, 2'd2, 2'd0, 3'b000};
  localparam logic [10:0] SEL_EXR_SLT = {3'd3, 1'b1, 2'd2, 2'd0, 3'b000};
  localparam logic [10:0] SEL_RWB     = {3'd0, 1'b0, 2'd0, 2'd0, 3'b001};
  localparam logic [10:0] SEL_EXI_ADD = {3'd0, 1'b1, 2'd1, 2'd0, 3'b000};
  localparam logic [10:0] SEL_EXI_XOR = {3'd2, 1'b1, 2'd1, 2'd0, 3'b000};
  localparam logic [10:0] SEL_IWB     = {3'd0, 1'b0, 2'd0, 2'd0, 3'b011};
  localparam logic [10:0] SEL_BRANCH  = {3'd1, 1'b1, 2'd2, 2'd0, 3'b000};
  localparam logic [10:0] SEL_JUMP    = {3'd0, 1'b0, 2'd0, 2'd2, 3'b000};
  localparam logic [10:0] SEL_JREG    = {3'd0, 1'b0, 2'd0, 2'd3, 3'b000};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle of the main instance, then advance to the next sample point.
  task automatic expect_cycle(input string tag, input logic [3:0] st,
                              input logic [6:0] en, input logic [10:0] sel);
    check({tag, " state"}, 32'(bus.state), 32'(st));
    check({tag, " en"},    32'(en_obs),    32'(en));
    check({tag, " sel"},   32'(sel_obs),   32'(sel));
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    reset_w     = 1'b1;
    bus.stall   = 1'b0;
    bus.cmd     = 4'd8;
    bus.eq      = 1'b0;
    bus_w.stall = 1'b0;
    bus_w.cmd   = 4'd2;
    bus_w.eq    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst state",   32'(bus.state), 32'd0);
    check("rst en",      32'(en_obs),    32'd0);
    check("rst sel",     32'(sel_obs),   32'd0);
    check("rst retired", bus.retired,    32'd0);
    reset = 1'b0;
    #1;

    // ADD
    expect_cycle("add fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("add decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("add exec",   4'd6, EN_NONE,   SEL_EXR_ADD);
    expect_cycle("add rwb",    4'd7, EN_REG,    SEL_RWB);
    check("add retired", bus.retired, 32'd1);

    // LW
    bus.cmd = 4'd0;
    expect_cycle("lw fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("lw decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("lw memadr", 4'd2, EN_NONE,   SEL_MEMADR);
    expect_cycle("lw memrd",  4'd3, EN_NONE,   SEL_MEMRD);
    expect_cycle("lw memwb",  4'd4, EN_REG,    SEL_MEMWB);
    check("lw retired", bus.retired, 32'd2);

    // SW
    bus.cmd = 4'd1;
    expect_cycle("sw fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("sw decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("sw memadr", 4'd2, EN_NONE,   SEL_MEMADR);
    expect_cycle("sw memwr",  4'd5, EN_MEMWR,  SEL_MEMRD);
    check("sw retired", bus.retired, 32'd3);

    // BEQ taken / not taken, BNE taken / not taken
    bus.cmd = 4'd4;
    bus.eq  = 1'b1;
    expect_cycle("beq1 fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("beq1 decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("beq1 branch", 4'd10, EN_PC,    SEL_BRANCH);
    check("beq1 retired", bus.retired, 32'd4);
    bus.eq = 1'b0;
    expect_cycle("beq0 fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("beq0 decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("beq0 branch", 4'd10, EN_NONE,  SEL_BRANCH);
    check("beq0 retired", bus.retired, 32'd5);
    bus.cmd = 4'd5;
    expect_cycle("bne0 fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("bne0 decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("bne0 branch", 4'd10, EN_PC,    SEL_BRANCH);
    check("bne0 retired", bus.retired, 32'd6);
    bus.eq = 1'b1;
    expect_cycle("bne1 fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("bne1 decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("bne1 branch", 4'd10, EN_NONE,  SEL_BRANCH);
    check("bne1 retired", bus.retired, 32'd7);
    bus.eq = 1'b0;

    // Illegal opcode, with a stall cycle in ILL masking the pulse
    bus.cmd = 4'd15;
    expect_cycle("ill fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("ill decode", 4'd1, EN_DECODE, SEL_ZERO);
    bus.stall = 1'b1;
    #1;
    check("ill stall en", 32'(en_obs), 32'(EN_NONE));
    @(negedge clk);
    #1;
    bus.stall = 1'b0;
    #1;
    expect_cycle("ill ill", 4'd13, EN_ILL, SEL_ZERO);
    check("ill next en",  32'(en_obs),  32'(EN_FETCH));
    check("ill retired", bus.retired, 32'd7);

    // SUB and SLT
    bus.cmd = 4'd9;
    expect_cycle("sub fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("sub decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("sub exec",   4'd6, EN_NONE,   SEL_EXR_SUB);
    expect_cycle("sub rwb",    4'd7, EN_REG,    SEL_RWB);
    bus.cmd = 4'd10;
    expect_cycle("slt fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("slt decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("slt exec",   4'd6, EN_NONE,   SEL_EXR_SLT);
    expect_cycle("slt rwb",    4'd7, EN_REG,    SEL_RWB);
    check("slt retired", bus.retired, 32'd9);

    // ADDI
    bus.cmd = 4'd6;
    expect_cycle("addi fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("addi decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("addi exec",   4'd8, EN_NONE,   SEL_EXI_ADD);
    expect_cycle("addi iwb",    4'd9, EN_REG,    SEL_IWB);
    check("addi retired", bus.retired, 32'd10);

    // XORI with stalls in FETCH, EXEC_I (3 cycles) and IWB
    bus.cmd   = 4'd7;
    bus.stall = 1'b1;
    #1;
    check("xori stall fetch en",  32'(en_obs),  32'(EN_NONE));
    check("xori stall fetch sel", 32'(sel_obs), 32'(SEL_FETCH));
    @(negedge clk);
    #1;
    check("xori stall fetch hold", 32'(bus.state), 32'd0);
    bus.stall = 1'b0;
    #1;
    expect_cycle("xori fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("xori decode", 4'd1, EN_DECODE, SEL_ZERO);
    bus.stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_cycle("xori stall exec", 4'd8, EN_NONE, SEL_EXI_XOR);
    end
    bus.stall = 1'b0;
    #1;
    expect_cycle("xori exec", 4'd8, EN_NONE, SEL_EXI_XOR);
    bus.stall = 1'b1;
    #1;
    check("xori stall iwb en", 32'(en_obs), 32'(EN_NONE));
    @(negedge clk);
    #1;
    check("xori stall iwb hold",    32'(bus.state), 32'd9);
    check("xori stall iwb retired", bus.retired,    32'd10);
    bus.stall = 1'b0;
    #1;
    expect_cycle("xori iwb", 4'd9, EN_REG, SEL_IWB);
    check("xori back to fetch", 32'(bus.state), 32'd0);
    check("xori retired",       bus.retired,    32'd11);

    // J and JR
    bus.cmd = 4'd2;
    expect_cycle("j fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("j decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("j jump",   4'd11, EN_PC,    SEL_JUMP);
    bus.cmd = 4'd3;
    expect_cycle("jr fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("jr decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("jr jreg",   4'd12, EN_PC,    SEL_JREG);
    check("jr retired", bus.retired, 32'd13);

    // Reset while in MEMRD abandons the LW
    bus.cmd = 4'd0;
    expect_cycle("rlw fetch",  4'd0, EN_FETCH,  SEL_FETCH);
    expect_cycle("rlw decode", 4'd1, EN_DECODE, SEL_ZERO);
    expect_cycle("rlw memadr", 4'd2, EN_NONE,   SEL_MEMADR);
    check("rlw memrd state", 32'(bus.state), 32'd3);
    reset = 1'b1;
    #1;
    check("rlw rst en",  32'(en_obs),  32'(EN_NONE));
    check("rlw rst sel", 32'(sel_obs), 32'(SEL_ZERO));
    @(negedge clk);
    #1;
    check("rlw rst state",   32'(bus.state), 32'd0);
    check("rlw rst retired", bus.retired,    32'd0);
    check("rlw rst regwe",   32'(bus.regWe), 32'd0);
    reset = 1'b0;
    #1;
    expect_cycle("rlw refetch", 4'd0, EN_FETCH, SEL_FETCH);
    check("rlw after retired", bus.retired, 32'd0);

    // Narrow counter: 16 jumps wrap 4'hF back to 0
    reset_w = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
    #1;
    check("wrap state",      32'(bus_w.state),   32'd0);
    check("wrap retired max", 32'(bus_w.retired), 32'd15);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("wrap retired zero", 32'(bus_w.retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control sequencer for the single-memory MIPS datapath.
- Consumes the decoded command and the ALU equality flag, and drives every mux select, ALU op and write enable the datapath needs.
- Moore-style FSM with stall support, an illegal-opcode flag and a retired-instruction counter.
- Sits beside the decoder inside the CPU top level.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the current state; all write enables forced 0.
- cmd  in  4  decoded command: 0 LW, 1 SW, 2 J, 3 JR, 4 BEQ, 5 BNE, 6 ADDI, 7 XORI, 8 ADD, 9 SUB, 10 SLT, others illegal.
- eq  in  1  ALU zero AND NOT overflow.
- aluOp  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT.
- aluSrcA  out  1  0 pc, 1 a.
- aluSrcB  out  2  0 sxi<<2, 1 sxi, 2 b, 3 constant 4.
- pcSrc  out  2  0 ffResult, 1 result, 2 jump target, 3 a.
- memIn  out  1  memory address: 0 pc, 1 ffResult.
- dst  out  1  register write address: 0 rd, 1 rt.
- regIn  out  1  register write data: 0 memory dOut, 1 ffResult.
- pcWe, memWe, irWe, aWe, bWe, regWe  out  1 each  write enables.
- illegal  out  1  one-cycle pulse in the ILL state.
- retired  out  CNT_W  count of completed instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - Ports are named clk and reset.
- Reset: while reset is high, all write enables, illegal and every select/op output are 0. On the next edge, state becomes FETCH(0) and retired becomes 0. Reset mid-instruction abandons that instruction; retired does not count it.
- State encodings and outputs. Every output not listed for a state is 0.
  - FETCH 0: memIn=0, irWe=1, aluSrcA=0, aluSrcB=3, aluOp=ADD, pcSrc=1, pcWe=1. Next: DECODE.
  - DECODE 1: aWe=1, bWe=1, aluSrcA=0, aluSrcB=0, aluOp=ADD. This computes the branch target, which lands in ffResult.
    - Next state by cmd: LW/SW to MEMADR; J to JUMP; JR to JREG; BEQ/BNE to BRANCH; ADDI/XORI to EXEC_I; ADD/SUB/SLT to EXEC_R; others to ILL.
  - MEMADR 2: aluSrcA=1, aluSrcB=1, aluOp=ADD. Next: MEMRD if cmd=LW, else MEMWR.
  - MEMRD 3: memIn=1. Next: MEMWB.
  - MEMWB 4: memIn=1, regIn=0, dst=1, regWe=1. Next: FETCH.
  - MEMWR 5: memIn=1, memWe=1. Next: FETCH.
  - EXEC_R 6: aluSrcA=1, aluSrcB=2, aluOp = ADD/SUB/SLT for cmd 8/9/10. Next: RWB.
  - RWB 7: regIn=1, dst=0, regWe=1. Next: FETCH.
  - EXEC_I 8: aluSrcA=1, aluSrcB=1, aluOp = ADD for ADDI, XOR for XORI. Next: IWB.
  - IWB 9: regIn=1, dst=1, regWe=1. Next: FETCH.
  - BRANCH 10: aluSrcA=1, aluSrcB=2, aluOp=SUB, pcSrc=0. pcWe=eq for BEQ, pcWe=!eq for BNE. Next: FETCH.
  - JUMP 11: pcSrc=2, pcWe=1. Next: FETCH.
  - JREG 12: pcSrc=3, pcWe=1. Next: FETCH.
  - ILL 13: illegal=1, no writes. Next: FETCH.
  - Encodings 14 and 15 are unreachable and recover to FETCH with no writes.
- cmd is sampled in DECODE and MEMADR, and in EXEC_R, EXEC_I and BRANCH for aluOp and pcWe selection. The decoder holds cmd stable from ir between FETCH edges.
- Latencies in cycles:
  - LW 5; SW 4.
  - R-type 4; I-type 4.
  - BEQ/BNE 3; J/JR 3.
  - Illegal 3.
- retired:
  - Increments by 1 on the edge leaving MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP or JREG.
  - ILL does not count.
  - Wraps at 2^CNT_W-1 to 0.
- stall:
  - While high, state and retired hold.
  - pcWe, memWe, irWe, aWe, bWe and regWe are forced 0; illegal is forced 0.
  - Selects and aluOp keep their state-derived values.
  - Stall deasserting resumes the same state with full outputs.
  - reset has priority over stall.

Test Plan:
- Reset then release, cmd=8 (ADD), eq=0: states 0,1,6,7,0. In RWB, regWe=1, regIn=1, dst=0. retired=1 after RWB. illegal never asserted.
- cmd=0 (LW): states 0,1,2,3,4,0. memIn=1 in states 3–4, regWe only in 4 with dst=1, regIn=0. cmd=1 (SW): memWe=1 only in state 5.
- cmd=4 (BEQ) with eq=1: pcWe=1 and pcSrc=0 in BRANCH. Same with eq=0: pcWe=0. cmd=5 (BNE): inverse. retired increments in all cases.
- cmd=15: states 0,1,13,0. illegal pulses for exactly 1 cycle; retired unchanged.
- Assert stall for 3 cycles in EXEC_I with cmd=7 (XORI): state stays 8, all enables 0, aluOp=2. After release: IWB then FETCH, 4 active cycles total.
- Preload retired=2^32-1 via instruction run; one J (cmd=2) retires and retired=0. Reset asserted during MEMRD: FETCH next, retired=0, no regWe ever pulsed.
